// File: rtl/fpu_mul_sequencer.sv
// Operand-issue and result-capture front end for the Top_Mul single-precision multiplier.
// Unpacks an accepted operand pair, waits MUL_LAT cycles, then holds the packed result and flags.
module fpu_mul_sequencer #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_rmode,
    output logic        Sx,
    output logic [7:0]  Ex,
    output logic [22:0] Mx,
    output logic        Sy,
    output logic [7:0]  Ey,
    output logic [22:0] My,
    output logic [1:0]  R_mode,
    output logic [1:0]  Mul_enable,
    input  logic        Sz,
    input  logic [7:0]  Ez,
    input  logic [22:0] Mz,
    input  logic        invalid_flag,
    input  logic        overflow_flag,
    input  logic        underflow_flag,
    input  logic        inexact_flag,
    input  logic        zero_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags,
    output logic [4:0]  sticky_flags,
    input  logic        flags_clr
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MUL_LAT);

    state_t     state, state_nxt;
    logic [3:0] lat_cnt;
    logic       accept;
    logic       capture;
    logic [4:0] mul_flags;

    assign mul_flags = {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag};

    // NOTE: every signal driven here gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        Mul_enable = 2'b00;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                Mul_enable = 2'b01;
                // Last execute cycle: the multiplier outputs are valid at this edge.
                if (lat_cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                lat_cnt <= LAT_LOAD;
            else if (state == EXEC)
                lat_cnt <= lat_cnt - 4'd1;
        end
    end

    // Operand fields change only on acceptance and hold through EXEC and DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Sx     <= 1'b0;
            Ex     <= '0;
            Mx     <= '0;
            Sy     <= 1'b0;
            Ey     <= '0;
            My     <= '0;
            R_mode <= '0;
        end else if (accept) begin
            Sx     <= in_a[31];
            Ex     <= in_a[30:23];
            Mx     <= in_a[22:0];
            Sy     <= in_b[31];
            Ey     <= in_b[30:23];
            My     <= in_b[22:0];
            R_mode <= in_rmode;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_result <= '0;
            out_flags  <= '0;
        end else if (capture) begin
            out_result <= {Sz, Ez, Mz};
            out_flags  <= mul_flags;
        end
    end

    // A clear coinciding with a capture keeps only the new flags.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            sticky_flags <= '0;
        else if (capture)
            sticky_flags <= flags_clr ? mul_flags : (sticky_flags | mul_flags);
        else if (flags_clr)
            sticky_flags <= '0;
    end

endmodule

// File: tb/tb_fpu_mul_sequencer.sv
// Bench for fpu_mul_sequencer: two instances (MUL_LAT=1 and 3) each driven by a toy multiplier
// stub that only presents a correct product on the last enabled cycle; results scoreboarded.
module tb_fpu_mul_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] in_a, in_b;
    logic [1:0]  in_rmode;
    logic        flags_clr;
    logic        v1, v3, r1, r3;

    logic        in_ready_1, out_valid_1, Sx_1, Sy_1, Sz_1;
    logic [7:0]  Ex_1, Ey_1, Ez_1;
    logic [22:0] Mx_1, My_1, Mz_1;
    logic [1:0]  R_mode_1, Mul_enable_1;
    logic [31:0] out_result_1;
    logic [4:0]  out_flags_1, sticky_1, mf_1;

    logic        in_ready_3, out_valid_3, Sx_3, Sy_3, Sz_3;
    logic [7:0]  Ex_3, Ey_3, Ez_3;
    logic [22:0] Mx_3, My_3, Mz_3;
    logic [1:0]  R_mode_3, Mul_enable_3;
    logic [31:0] out_result_3;
    logic [4:0]  out_flags_3, sticky_3, mf_3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ecnt_1   = 0;
    int ecnt_3   = 0;
    logic [36:0] q1[$];
    logic [36:0] q3[$];
    logic [36:0] z_1, z_3, exp_1, exp_3;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    fpu_mul_sequencer #(.MUL_LAT(1)) u_lat1 (
        .CLK(CLK), .RST(RST), .in_valid(v1), .in_ready(in_ready_1),
        .in_a(in_a), .in_b(in_b), .in_rmode(in_rmode),
        .Sx(Sx_1), .Ex(Ex_1), .Mx(Mx_1), .Sy(Sy_1), .Ey(Ey_1), .My(My_1),
        .R_mode(R_mode_1), .Mul_enable(Mul_enable_1),
        .Sz(Sz_1), .Ez(Ez_1), .Mz(Mz_1),
        .invalid_flag(mf_1[4]), .overflow_flag(mf_1[3]), .underflow_flag(mf_1[2]),
        .inexact_flag(mf_1[1]), .zero_flag(mf_1[0]),
        .out_valid(out_valid_1), .out_ready(r1), .out_result(out_result_1),
        .out_flags(out_flags_1), .sticky_flags(sticky_1), .flags_clr(flags_clr)
    );

    fpu_mul_sequencer #(.MUL_LAT(3)) u_lat3 (
        .CLK(CLK), .RST(RST), .in_valid(v3), .in_ready(in_ready_3),
        .in_a(in_a), .in_b(in_b), .in_rmode(in_rmode),
        .Sx(Sx_3), .Ex(Ex_3), .Mx(Mx_3), .Sy(Sy_3), .Ey(Ey_3), .My(My_3),
        .R_mode(R_mode_3), .Mul_enable(Mul_enable_3),
        .Sz(Sz_3), .Ez(Ez_3), .Mz(Mz_3),
        .invalid_flag(mf_3[4]), .overflow_flag(mf_3[3]), .underflow_flag(mf_3[2]),
        .inexact_flag(mf_3[1]), .zero_flag(mf_3[0]),
        .out_valid(out_valid_3), .out_ready(r3), .out_result(out_result_3),
        .out_flags(out_flags_3), .sticky_flags(sticky_3), .flags_clr(flags_clr)
    );

    // Toy truncating multiplier: returns {invalid, overflow, underflow, inexact, zero, result}.
    function automatic logic [36:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        logic        inx;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {5'b00001, s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m   = p[46:24];
            inx = |p[23:0];
            e   = e + 1;
        end else begin
            m   = p[45:23];
            inx = |p[22:0];
        end
        if (e >= 255) return {5'b01000, s, 8'hFF, 23'd0};
        if (e <= 0)   return {5'b00111, s, 31'd0};
        return {3'b000, inx, 1'b0, s, e[7:0], m};
    endfunction

    // Stub outputs are corrupted except on the MUL_LAT-th consecutive enabled cycle.
    always @(posedge CLK) begin
        ecnt_1 <= (Mul_enable_1 == 2'b01) ? ecnt_1 + 1 : 0;
        ecnt_3 <= (Mul_enable_3 == 2'b01) ? ecnt_3 + 1 : 0;
    end

    always @* begin
        z_1 = mul_model({Sx_1, Ex_1, Mx_1}, {Sy_1, Ey_1, My_1});
        if (!(Mul_enable_1 == 2'b01 && ecnt_1 == 0)) z_1 = z_1 ^ {5'h1F, 32'hA5A5A5A5};
        z_3 = mul_model({Sx_3, Ex_3, Mx_3}, {Sy_3, Ey_3, My_3});
        if (!(Mul_enable_3 == 2'b01 && ecnt_3 == 2)) z_3 = z_3 ^ {5'h1F, 32'hA5A5A5A5};
    end

    assign {mf_1, Sz_1, Ez_1, Mz_1} = z_1;
    assign {mf_3, Sz_3, Ez_3, Mz_3} = z_3;

    // Scoreboard: every output handshake pops and compares the oldest expected result.
    always @(negedge CLK) begin
        if (!RST && out_valid_1 && r1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL sb_lat1_unexpected got=%h", {out_flags_1, out_result_1});
            end else begin
                exp_1 = q1.pop_front();
                if ({out_flags_1, out_result_1} !== exp_1) begin
                    failures++;
                    $display("FAIL sb_lat1_result got=%h exp=%h", {out_flags_1, out_result_1}, exp_1);
                end
            end
        end
        if (!RST && out_valid_3 && r3) begin
            checks++;
            if (q3.size() == 0) begin
                failures++;
                $display("FAIL sb_lat3_unexpected got=%h", {out_flags_3, out_result_3});
            end else begin
                exp_3 = q3.pop_front();
                if ({out_flags_3, out_result_3} !== exp_3) begin
                    failures++;
                    $display("FAIL sb_lat3_result got=%h exp=%h", {out_flags_3, out_result_3}, exp_3);
                end
            end
        end
    end

    // Presents one operand pair until accepted; returns one time unit after the accepting edge.
    task automatic issue(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        bit done = 1'b0;
        in_a = a; in_b = b; in_rmode = rm;
        if (sel) v3 = 1'b1; else v1 = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (sel ? in_ready_3 : in_ready_1) begin
                if (sel) q3.push_back(mul_model(a, b)); else q1.push_back(mul_model(a, b));
                done = 1'b1;
            end
            @(posedge CLK); #1;
        end
        v1 = 1'b0; v3 = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL issue_timeout got=not_accepted exp=accepted"); end
    endtask

    task automatic wait_out(input bit sel);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            seen = sel ? out_valid_3 : out_valid_1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL wait_out_timeout got=0 exp=1"); end
    endtask

    task automatic test_reset(input bit loaded);
        if (loaded) begin
            r1 = 1'b0;
            issue(1'b0, 32'hBF800000, 32'h40000000, 2'b11);
            wait_out(1'b0);
        end
        #2; RST = 1'b1; #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ((d == 0 ? {Sx_1, Ex_1, Mx_1, Sy_1, Ey_1, My_1, R_mode_1}
                        : {Sx_3, Ex_3, Mx_3, Sy_3, Ey_3, My_3, R_mode_3}) !== 66'd0) begin
                failures++; $display("FAIL reset_fields dut=%0d got=nonzero exp=0", d);
            end
            checks++;
            if ((d == 0 ? {out_valid_1, out_result_1, out_flags_1, sticky_1, Mul_enable_1}
                        : {out_valid_3, out_result_3, out_flags_3, sticky_3, Mul_enable_3}) !== 45'd0) begin
                failures++; $display("FAIL reset_outputs dut=%0d got=nonzero exp=0", d);
            end
            checks++;
            if ((d == 0 ? in_ready_1 : in_ready_3) !== 1'b1) begin
                failures++; $display("FAIL reset_in_ready dut=%0d got=0 exp=1", d);
            end
        end
        q1.delete(); q3.delete();
        @(posedge CLK); #3; RST = 1'b0;
        @(posedge CLK); #1;
        r1 = 1'b1; r3 = 1'b1;
    endtask

    task automatic test_basic;
        r1 = 1'b0;
        issue(1'b0, 32'h3FC00000, 32'h40000000, 2'b00);
        @(negedge CLK);
        checks++;
        if (Mul_enable_1 !== 2'b01 || out_valid_1 !== 1'b0) begin
            failures++; $display("FAIL basic_exec got=%b/%b exp=01/0", Mul_enable_1, out_valid_1);
        end
        checks++;
        if ({Sx_1, Ex_1, Mx_1, Sy_1, Ey_1, My_1, R_mode_1} !== {1'b0, 8'h7F, 23'h400000, 1'b0, 8'h80, 23'h0, 2'b00}) begin
            failures++; $display("FAIL basic_fields got=%h %h %h %h %h %h exp=0 7f 400000 0 80 0", Sx_1, Ex_1, Mx_1, Sy_1, Ey_1, My_1);
        end
        @(negedge CLK);
        checks++;
        if (out_valid_1 !== 1'b1 || Mul_enable_1 !== 2'b00) begin
            failures++; $display("FAIL basic_latency got=%b/%b exp=1/00", out_valid_1, Mul_enable_1);
        end
        checks++;
        if (out_result_1 !== 32'h40400000 || out_flags_1 !== 5'b00000) begin
            failures++; $display("FAIL basic_result got=%h/%b exp=40400000/00000", out_result_1, out_flags_1);
        end
        @(posedge CLK); #1;
        r1 = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure;
        r1 = 1'b0;
        issue(1'b0, 32'h3F800000, 32'hC0400000, 2'b10);
        wait_out(1'b0);
        @(posedge CLK); #1;
        in_a = 32'h12345678; in_b = 32'h9ABCDEF0; in_rmode = 2'b01; v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (out_valid_1 !== 1'b1 || in_ready_1 !== 1'b0 || out_result_1 !== 32'hC0400000 || out_flags_1 !== 5'd0) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=%b %b %h %b exp=1 0 c0400000 00000", i, out_valid_1, in_ready_1, out_result_1, out_flags_1);
            end
            checks++;
            if ({Sx_1, Ex_1, Mx_1, Sy_1, Ey_1, My_1, R_mode_1} !== {32'h3F800000, 32'hC0400000, 2'b10}) begin
                failures++; $display("FAIL bp_fields cyc=%0d got=%h%h exp=3f800000c0400000", i, {Sx_1, Ex_1, Mx_1}, {Sy_1, Ey_1, My_1});
            end
            @(posedge CLK); #1;
        end
        r1 = 1'b1;
        @(posedge CLK); #1;
        v1 = 1'b0;
        @(negedge CLK);
        checks++;
        if (in_ready_1 !== 1'b1 || out_valid_1 !== 1'b0 || {Sx_1, Ex_1, Mx_1} !== 32'h3F800000) begin
            failures++; $display("FAIL bp_release got=%b %b %h exp=1 0 3f800000", in_ready_1, out_valid_1, {Sx_1, Ex_1, Mx_1});
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_sticky;
        flags_clr = 1'b1;
        @(posedge CLK); #1;
        flags_clr = 1'b0;
        @(negedge CLK);
        checks++;
        if (sticky_1 !== 5'b00000) begin failures++; $display("FAIL sticky_clear got=%b exp=00000", sticky_1); end
        @(posedge CLK); #1;
        issue(1'b0, 32'h7F000000, 32'h40000000, 2'b00);
        wait_out(1'b0);
        checks++;
        if (sticky_1 !== 5'b01000) begin failures++; $display("FAIL sticky_overflow got=%b exp=01000", sticky_1); end
        @(posedge CLK); #1;
        issue(1'b0, 32'h3FC00001, 32'h3FC00001, 2'b01);
        wait_out(1'b0);
        checks++;
        if (sticky_1 !== 5'b01010) begin failures++; $display("FAIL sticky_inexact got=%b exp=01010", sticky_1); end
        @(posedge CLK); #1;
        issue(1'b0, 32'h00000000, 32'h3F800000, 2'b00);
        flags_clr = 1'b1;
        @(posedge CLK); #1;
        flags_clr = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_valid_1 !== 1'b1 || out_flags_1 !== 5'b00001 || sticky_1 !== 5'b00001) begin
            failures++; $display("FAIL sticky_clr_capture got=%b %b %b exp=1 00001 00001", out_valid_1, out_flags_1, sticky_1);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_exec;
        issue(1'b1, 32'h7F000000, 32'h40000000, 2'b01);
        wait_out(1'b1);
        checks++;
        if (sticky_3 !== 5'b01000) begin failures++; $display("FAIL rexec_pre_sticky got=%b exp=01000", sticky_3); end
        @(posedge CLK); #1;
        issue(1'b1, 32'h3FC00000, 32'h40000000, 2'b00);
        @(posedge CLK); #2;
        RST = 1'b1; #1;
        q3.delete();
        checks++;
        if (out_valid_3 !== 1'b0 || sticky_3 !== 5'd0 || in_ready_3 !== 1'b1 || Mul_enable_3 !== 2'b00) begin
            failures++; $display("FAIL rexec_reset got=%b %b %b %b exp=0 00000 1 00", out_valid_3, sticky_3, in_ready_3, Mul_enable_3);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (out_valid_3 !== 1'b0) begin failures++; $display("FAIL rexec_no_valid got=1 exp=0"); end
        end
        @(posedge CLK); #3;
        RST = 1'b0;
        in_a = 32'h40000000; in_b = 32'h40000000; in_rmode = 2'b01; v3 = 1'b1;
        @(negedge CLK);
        checks++;
        if (in_ready_3 !== 1'b1) begin failures++; $display("FAIL rexec_ready got=0 exp=1"); end
        q3.push_back(mul_model(32'h40000000, 32'h40000000));
        @(posedge CLK); #1;
        v3 = 1'b0;
        checks++;
        if (Mul_enable_3 !== 2'b01 || {Sx_3, Ex_3, Mx_3} !== 32'h40000000 || R_mode_3 !== 2'b01) begin
            failures++; $display("FAIL rexec_first_accept got=%b %h %b exp=01 40000000 01", Mul_enable_3, {Sx_3, Ex_3, Mx_3}, R_mode_3);
        end
        wait_out(1'b1);
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        int idx  = 0;
        int last = -1;
        bit acc;
        ta = '{32'h3FC00000, 32'h40400000, 32'hC1200000, 32'h3F800001};
        tb = '{32'h3FC00000, 32'h40800000, 32'h3DCCCCCD, 32'h00000000};
        in_a = ta[0]; in_b = tb[0]; in_rmode = 2'b11; v3 = 1'b1; r3 = 1'b1;
        for (int c = 0; c < 100 && idx < 4; c++) begin
            @(negedge CLK);
            acc = in_ready_3;
            if (acc) begin
                q3.push_back(mul_model(in_a, in_b));
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 5) begin failures++; $display("FAIL b2b_interval got=%0d exp=5", cyc - last); end
                end
                last = cyc;
            end
            @(posedge CLK); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin in_a = ta[idx]; in_b = tb[idx]; end
            end
        end
        v3 = 1'b0;
        checks++;
        if (idx != 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", idx); end
        for (int i = 0; i < 40 && q3.size() != 0; i++) @(posedge CLK);
        #1;
        checks++;
        if (q3.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", q3.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b0; in_a = '0; in_b = '0; in_rmode = '0; flags_clr = 1'b0;
        v1 = 1'b0; v3 = 1'b0; r1 = 1'b0; r3 = 1'b0;
        test_reset(1'b0);
        test_basic;
        test_backpressure;
        test_sticky;
        test_reset(1'b1);
        test_reset_exec;
        test_back_to_back;
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL sb_lat1_leftover got=%0d exp=0", q1.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_mul_sequencer.md
# fpu_mul_sequencer

Operand-issue and result-capture front end for the `Top_Mul` single-precision multiplier. It accepts packed 32-bit IEEE-754 operand pairs over a valid/ready handshake. It unpacks them onto the multiplier's split sign/exponent/mantissa field interface and waits a fixed multiplier latency. It then captures `Sz`/`Ez`/`Mz` and the five status flags, and presents a packed 32-bit result over a second valid/ready handshake, accumulating flags into a sticky register (fflags-style).

## Interface
Parameters:
- `MUL_LAT`, 1, cycles `Top_Mul` needs from stable operands with `Mul_enable` asserted to valid `Sz/Ez/Mz`/flags; legal range 1–15.

Ports:
- `CLK` in 1: single clock, all state on rising edge.
- `RST` in 1: asynchronous reset, active-high.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: sequencer can accept.
- `in_a` in 32: packed operand x.
- `in_b` in 32: packed operand y.
- `in_rmode` in 2: rounding mode for this operation.
- `Sx` out 1, `Ex` out 8, `Mx` out 23: unpacked `in_a` to multiplier.
- `Sy` out 1, `Ey` out 8, `My` out 23: unpacked `in_b` to multiplier.
- `R_mode` out 2: registered `in_rmode`.
- `Mul_enable` out 2: 2'b01 while executing, 2'b00 otherwise.
- `Sz` in 1, `Ez` in 8, `Mz` in 23: multiplier result fields.
- `invalid_flag`, `overflow_flag`, `underflow_flag`, `inexact_flag`, `zero_flag` in 1 each: multiplier flags.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts.
- `out_result` out 32: {Sz, Ez, Mz} as captured.
- `out_flags` out 5: {invalid, overflow, underflow, inexact, zero} as captured.
- `sticky_flags` out 5: OR of all captured `out_flags` since last clear.
- `flags_clr` in 1: synchronous clear of `sticky_flags`.

## Operation
- States: IDLE, EXEC, DONE. `in_ready` = (state == IDLE); `out_valid` = (state == DONE).
- IDLE, on `in_valid` & `in_ready`:
  - Register `Sx=in_a[31]`, `Ex=in_a[30:23]`, `Mx=in_a[22:0]` (same split for y) and `R_mode=in_rmode`.
  - Load the latency counter with `MUL_LAT`.
  - Go to EXEC.
- EXEC:
  - `Mul_enable`=2'b01; the counter decrements each cycle.
  - In the cycle where the counter equals 1, capture `out_result={Sz,Ez,Mz}` and `out_flags` at the clock edge, update sticky, and go to DONE.
- DONE:
  - `out_result`/`out_flags` stay stable until `out_valid` & `out_ready`, then go to IDLE.
  - No new operand is accepted in the handshake cycle; `in_ready` rises the next cycle.
- Operand/`R_mode` field outputs hold their last values outside EXEC; they change only on acceptance.
- `in_valid` while not IDLE is ignored (not latched).
- No result post-processing: no NaN canonicalisation and no flag masking. Fields pass through bit-exact.
- Sticky register, next value per cycle:
  - capture & `flags_clr` → `out_flags` (new value).
  - capture only → `sticky | out_flags`.
  - `flags_clr` only → 0.
  - otherwise → hold.

## Timing
- Reset (async, immediate):
  - state IDLE (`in_ready`=1 during and after reset), `out_valid`=0, `Mul_enable`=2'b00.
  - All field outputs, `R_mode`, `out_result`, `out_flags` and `sticky_flags` = 0; counter = 0.
- Latency: accept at edge T0 → EXEC cycles T0+1 … T0+MUL_LAT → `out_valid` high from T0+MUL_LAT+1.
- Throughput with `out_ready` held high: one operation per MUL_LAT+2 cycles.
- Reset asserted in EXEC or DONE: the operation is dropped, no result is produced and sticky is cleared. The first acceptance is possible in the first cycle after deassertion.
- `flags_clr` is honoured in any state.

## Test plan
1. **Reset values:** assert `RST` mid-cycle → all outputs zero at once, `in_ready`=1, `Mul_enable`=2'b00.
2. **Basic multiply (1.5 × 2.0)**, `MUL_LAT`=1: `in_a`=0x3FC00000, `in_b`=0x40000000, rmode 2'b00.
   - Fields: `Sx`=0, `Ex`=0x7F, `Mx`=0x400000, `Ey`=0x80, `My`=0.
   - `out_result`=0x40400000 and `out_flags`=0, with `out_valid` at T0+2.
3. **Backpressure:** hold `out_ready` low for 5 cycles in DONE.
   - `out_valid`, `out_result` and `out_flags` stay stable; `in_ready`=0.
   - A concurrent `in_valid` is not accepted; the fields are unchanged.
4. **Sticky flags:**
   - Op with overflow → sticky 5'b01000.
   - Then op with inexact → 5'b01010.
   - Then `flags_clr` in the same cycle as capturing a zero-flag op → 5'b00001.
5. **Reset mid-EXEC**, `MUL_LAT`=3: assert `RST` on the 2nd EXEC cycle.
   - No `out_valid` afterwards and sticky = 0.
   - The next operand is accepted in the first cycle after deassertion.
6. **Back-to-back**, `MUL_LAT`=3, `in_valid` and `out_ready` held high: acceptances exactly 5 cycles apart, and results delivered in order.
